// File: rtl/rom_stream_loader.sv
// Fills CHIP-8 memory: an optional 80-byte hex font, then a valid/ready ROM byte stream from LOAD_BASE.
// Latency: each accepted stream byte appears on the registered write port one cycle later; font writes one per cycle.
// Backpressure: s_ready_out is high only in LOAD, so the source stalls during IDLE/FONT/DONE/ERROR.
module rom_stream_loader #(
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 4096,
  parameter int LOAD_BASE = 'h200,
  parameter int FONT_EN   = 1,
  parameter int FONT_BASE = 'h000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              s_valid_in,
  input  logic [7:0]        s_data_in,
  input  logic              s_last_in,
  output logic              s_ready_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_wdata_out,
  output logic              busy_out,
  output logic              rom_ready,
  output logic [ADDR_W:0]   rom_size_out,
  output logic              overflow_err_out
);

  // Bytes of memory available to the ROM image above its base address.
  localparam logic [ADDR_W:0]   CAP   = (ADDR_W+1)'(MEM_DEPTH - LOAD_BASE);
  localparam logic [ADDR_W-1:0] LBASE = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] FBASE = ADDR_W'(FONT_BASE);
  localparam logic [6:0]        FONT_LAST = 7'd79;

  // Glyphs 0..F, five rows each; byte 0 sits in the most significant position.
  localparam logic [639:0] FONT_ROM = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FONT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [6:0]          font_idx, font_idx_nxt;
  logic [ADDR_W:0]     count, count_nxt;
  logic                we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [7:0]          wdata_nxt;
  logic                ready_nxt;
  logic                err_nxt;
  logic [9:0]          font_bit;
  logic [7:0]          font_byte;
  logic                accept;

  // Stream handshake and status are pure functions of the current state.
  assign s_ready_out  = (state == ST_LOAD);
  assign busy_out     = (state == ST_FONT) || (state == ST_LOAD);
  assign accept       = s_valid_in && s_ready_out;
  assign rom_size_out = count;

  // Font byte lookup: byte i lives at bit offset (79-i)*8 = 632 - 8*i.
  assign font_bit  = 10'd632 - {font_idx, 3'b000};
  assign font_byte = FONT_ROM[font_bit +: 8];

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      font_idx         <= '0;
      count            <= '0;
      mem_we_out       <= 1'b0;
      mem_addr_out     <= '0;
      mem_wdata_out    <= '0;
      rom_ready        <= 1'b0;
      overflow_err_out <= 1'b0;
    end else begin
      state            <= state_nxt;
      font_idx         <= font_idx_nxt;
      count            <= count_nxt;
      mem_we_out       <= we_nxt;
      mem_addr_out     <= addr_nxt;
      mem_wdata_out    <= wdata_nxt;
      rom_ready        <= ready_nxt;
      overflow_err_out <= err_nxt;
    end
  end

  // Next-state and next write-port values; write strobe defaults low every cycle.
  always_comb begin
    state_nxt    = state;
    font_idx_nxt = font_idx;
    count_nxt    = count;
    we_nxt       = 1'b0;
    addr_nxt     = mem_addr_out;
    wdata_nxt    = mem_wdata_out;
    ready_nxt    = rom_ready;
    err_nxt      = overflow_err_out;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_in) begin
          state_nxt    = (FONT_EN != 0) ? ST_FONT : ST_LOAD;
          font_idx_nxt = '0;
          count_nxt    = '0;
          ready_nxt    = 1'b0;
          err_nxt      = 1'b0;
        end
      end
      ST_FONT: begin
        we_nxt    = 1'b1;
        addr_nxt  = FBASE + ADDR_W'(font_idx);
        wdata_nxt = font_byte;
        if (font_idx == FONT_LAST) begin
          state_nxt = ST_LOAD;
        end else begin
          font_idx_nxt = font_idx + 7'd1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (count == CAP) begin
            // Memory is full: drop the byte rather than wrap onto the font.
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            we_nxt    = 1'b1;
            addr_nxt  = LBASE + count[ADDR_W-1:0];
            wdata_nxt = s_data_in;
            count_nxt = count + 1'b1;
            if (s_last_in) begin
              state_nxt = ST_DONE;
              ready_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench for rom_stream_loader: one instance with the font, one without.
// Stimulus tasks push expected writes (with their due cycle); per-instance monitors pop and compare.
// Backpressure is modelled from the expected load window, independently of the DUT.
module tb_rom_stream_loader;

  localparam int CAP = 4096 - 'h200;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [7:0]  dat;
    logic        last;
    logic [12:0] size;
  } exp_t;

  logic clk;
  logic rst;
  logic [1:0]       start, valid, lastv;
  logic [1:0][7:0]  data;
  logic [1:0]       s_ready, we, busy, rdy, err;
  logic [1:0][11:0] addr;
  logic [1:0][7:0]  wdat;
  logic [1:0][12:0] size;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n [2];
  int load_from [2];
  bit loading [2];
  exp_t q0 [$];
  exp_t q1 [$];

  logic [7:0] font_t [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  rom_stream_loader #(.FONT_EN(1)) u_font (
    .clk_in(clk), .rst_in(rst), .start_in(start[0]),
    .s_valid_in(valid[0]), .s_data_in(data[0]), .s_last_in(lastv[0]),
    .s_ready_out(s_ready[0]), .mem_we_out(we[0]), .mem_addr_out(addr[0]),
    .mem_wdata_out(wdat[0]), .busy_out(busy[0]), .rom_ready(rdy[0]),
    .rom_size_out(size[0]), .overflow_err_out(err[0])
  );

  rom_stream_loader #(.FONT_EN(0)) u_nofont (
    .clk_in(clk), .rst_in(rst), .start_in(start[1]),
    .s_valid_in(valid[1]), .s_data_in(data[1]), .s_last_in(lastv[1]),
    .s_ready_out(s_ready[1]), .mem_we_out(we[1]), .mem_addr_out(addr[1]),
    .mem_wdata_out(wdat[1]), .busy_out(busy[1]), .rom_ready(rdy[1]),
    .rom_size_out(size[1]), .overflow_err_out(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Compare one cycle of the write port of instance d against its queue head.
  task automatic mon(input int d);
    exp_t e;
    bit   have;
    have = 0;
    if (d == 0 && q0.size() > 0) begin e = q0[0]; have = 1; end
    if (d == 1 && q1.size() > 0) begin e = q1[0]; have = 1; end
    if (we[d]) begin
      if (!have) begin
        chk($sformatf("unexpected_write%0d", d), 32'(addr[d]), 32'hFFFF_FFFF);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("write_cycle%0d", d), 32'(cyc), 32'(e.cyc));
        chk($sformatf("write_addr%0d", d), 32'(addr[d]), 32'(e.addr));
        chk($sformatf("write_data%0d", d), 32'(wdat[d]), 32'(e.dat));
        chk($sformatf("rom_ready_at_write%0d", d), 32'(rdy[d]), 32'(e.last));
        if (e.last) chk($sformatf("rom_size_at_last%0d", d), 32'(size[d]), 32'(e.size));
      end
    end else if (have && e.cyc <= cyc) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      chk($sformatf("missing_write%0d_addr%0h", d, e.addr), 32'(we[d]), 32'd1);
    end
  endtask

  always @(negedge clk) if (!rst) mon(0);
  always @(negedge clk) if (!rst) mon(1);

  // Pulse start from a quiescent state and queue the font writes it implies.
  task automatic do_start(input int d);
    exp_t e;
    int c;
    @(negedge clk);
    start[d] = 1'b1; valid[d] = 1'b0; lastv[d] = 1'b0;
    c = cyc;
    n[d] = 0;
    loading[d] = 1'b1;
    load_from[d] = (d == 0) ? c + 81 : c + 1;
    if (d == 0) begin
      for (int i = 0; i < 80; i++) begin
        e.cyc = c + 2 + i; e.addr = 12'(i); e.dat = font_t[i]; e.last = 1'b0; e.size = '0;
        push(d, e);
      end
    end
  endtask

  task automatic idle(input int d, input int k);
    repeat (k) begin
      @(negedge clk);
      start[d] = 1'b0; valid[d] = 1'b0; lastv[d] = 1'b0;
    end
  endtask

  task automatic pulse(input int d);
    @(negedge clk);
    start[d] = 1'b1; valid[d] = 1'b0; lastv[d] = 1'b0;
  endtask

  // Offer one byte, holding valid until the modelled load window accepts it.
  task automatic send(input int d, input logic [7:0] b, input logic last, input logic st);
    exp_t e;
    bit acc;
    bit exp_rdy;
    int guard;
    acc = 0; guard = 0;
    while (!acc) begin
      @(negedge clk);
      start[d] = st; valid[d] = 1'b1; data[d] = b; lastv[d] = last;
      exp_rdy = loading[d] && (cyc >= load_from[d]);
      chk($sformatf("s_ready%0d", d), 32'(s_ready[d]), 32'(exp_rdy));
      if (exp_rdy) acc = 1;
      guard++;
      if (!acc && guard > 200) begin
        chk("accept_timeout", 32'(guard), 32'd0);
        acc = 1; exp_rdy = 0;
      end
    end
    if (exp_rdy) begin
      if (n[d] < CAP) begin
        e.cyc = cyc + 1; e.addr = 12'('h200 + n[d]); e.dat = b; e.last = last; e.size = 13'(n[d] + 1);
        push(d, e);
        n[d]++;
        if (last) loading[d] = 1'b0;
      end else begin
        loading[d] = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = '0; valid = '0; lastv = '0; data = '0;
    loading[0] = 0; loading[1] = 0; n[0] = 0; n[1] = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_we", 32'(we[d]), 0);
      chk("reset_busy", 32'(busy[d]), 0);
      chk("reset_s_ready", 32'(s_ready[d]), 0);
      chk("reset_rom_ready", 32'(rdy[d]), 0);
      chk("reset_err", 32'(err[d]), 0);
      chk("reset_size", 32'(size[d]), 0);
      chk("reset_addr", 32'(addr[d]), 0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(0, 2);

    // Font preload then a 4-byte image.
    do_start(0);
    send(0, 8'hA2, 0, 0); send(0, 8'h2A, 0, 0); send(0, 8'h60, 0, 0); send(0, 8'h0C, 1, 0);
    idle(0, 3);
    chk("s1_busy", 32'(busy[0]), 0);
    chk("s1_rom_ready", 32'(rdy[0]), 1);
    chk("s1_size", 32'(size[0]), 4);
    chk("s1_err", 32'(err[0]), 0);
    chk("s1_s_ready", 32'(s_ready[0]), 0);

    // Image that exactly fills memory up to 0xFFF.
    do_start(0);
    for (int i = 0; i < CAP; i++) send(0, 8'(i * 7 + 3), logic'(i == CAP - 1), 0);
    idle(0, 2);
    chk("s3_rom_ready", 32'(rdy[0]), 1);
    chk("s3_size", 32'(size[0]), CAP);
    chk("s3_err", 32'(err[0]), 0);

    // One byte too many without last: dropped, error raised.
    do_start(0);
    for (int i = 0; i < CAP + 1; i++) send(0, 8'(i * 5 + 1), 0, 0);
    idle(0, 2);
    chk("s4_err", 32'(err[0]), 1);
    chk("s4_s_ready", 32'(s_ready[0]), 0);
    chk("s4_rom_ready", 32'(rdy[0]), 0);
    chk("s4_busy", 32'(busy[0]), 0);
    chk("s4_size", 32'(size[0]), CAP);
    do_start(0);
    idle(0, 1);
    chk("s4_err_cleared", 32'(err[0]), 0);
    chk("s4_busy_restart", 32'(busy[0]), 1);
    chk("s4_size_cleared", 32'(size[0]), 0);
    send(0, 8'h12, 0, 0); send(0, 8'h34, 1, 0);
    idle(0, 2);
    chk("s4_rom_ready_after", 32'(rdy[0]), 1);

    // Asynchronous reset with a write on the port mid-load.
    do_start(0);
    for (int i = 0; i < 11; i++) send(0, 8'(8'h40 + i), 0, 0);
    @(posedge clk);
    #1;
    chk("s5_we_before_rst", 32'(we[0]), 1);
    #1;
    rst = 1'b1; valid[0] = 1'b0;
    q0.delete(); loading[0] = 0;
    #1;
    chk("s5_rst_we", 32'(we[0]), 0);
    chk("s5_rst_busy", 32'(busy[0]), 0);
    chk("s5_rst_s_ready", 32'(s_ready[0]), 0);
    chk("s5_rst_size", 32'(size[0]), 0);
    chk("s5_rst_addr", 32'(addr[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(0, 3);
    do_start(0);
    send(0, 8'h01, 0, 0); send(0, 8'h02, 0, 0); send(0, 8'h03, 1, 0);
    idle(0, 2);
    chk("s5_size_after", 32'(size[0]), 3);

    // Start pulses in FONT and LOAD are ignored; in DONE they restart.
    do_start(0);
    idle(0, 20);
    pulse(0);
    send(0, 8'h11, 0, 0); send(0, 8'h22, 0, 1); send(0, 8'h33, 1, 0);
    idle(0, 2);
    chk("s6_rom_ready", 32'(rdy[0]), 1);
    chk("s6_size", 32'(size[0]), 3);
    do_start(0);
    idle(0, 1);
    chk("s6_rom_ready_drop", 32'(rdy[0]), 0);
    send(0, 8'h44, 1, 0);
    idle(0, 2);
    chk("s6_size_rerun", 32'(size[0]), 1);

    // No font: ready right after start, valid toggling every other cycle.
    do_start(1);
    for (int i = 0; i < 6; i++) begin
      send(1, 8'(8'hC0 + 3 * i), logic'(i == 5), 0);
      idle(1, 1);
    end
    idle(1, 2);
    chk("s2_rom_ready", 32'(rdy[1]), 1);
    chk("s2_size", 32'(size[1]), 6);

    idle(0, 5);
    chk("queue0_drained", 32'(q0.size()), 0);
    chk("queue1_drained", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_stream_loader.md
Name: rom_stream_loader

Overview:
Parametrised loader that fills CHIP-8 main memory before the CPU starts. It can optionally preload the built-in hex font. It then accepts a ROM image as a valid/ready byte stream and writes it, one byte per cycle, through a registered memory write port starting at a configurable base address. It signals completion with rom_ready, and detects overflow of the image past the end of memory.

Parameters:
ADDR_W, 12, memory address width
MEM_DEPTH, 4096, number of bytes in the target memory; must be ≤ 2**ADDR_W
LOAD_BASE, 'h200, address of the first ROM byte
FONT_EN, 1, if 1 then preload the 80-byte hex font before loading the ROM
FONT_BASE, 'h000, address of the first font byte; FONT_BASE+80 ≤ LOAD_BASE

Ports:
clk_in  input  1  system clock; all state updates on the rising edge
rst_in  input  1  reset, asynchronous and active-high
start_in  input  1  one-cycle request to begin a load sequence
s_valid_in  input  1  stream byte valid
s_data_in  input  8  stream byte
s_last_in  input  1  marks the final byte of the image (qualified by s_valid_in)
s_ready_out  output  1  loader accepts a stream byte this cycle
mem_we_out  output  1  memory write strobe (registered)
mem_addr_out  output  ADDR_W  memory write address (registered)
mem_wdata_out  output  8  memory write data (registered)
busy_out  output  1  high in the FONT and LOAD states
rom_ready  output  1  image fully written; CPU may run
rom_size_out  output  ADDR_W+1  number of ROM bytes written
overflow_err_out  output  1  image exceeded memory; sticky until the next start or reset

Behaviour:
- Reset (asynchronous, on rst_in high):
  - State goes to IDLE.
  - All outputs go to 0, including rom_size_out.
  - Reset mid-operation abandons the load; no further writes occur.
- States: IDLE, FONT, LOAD, DONE, ERROR.
- IDLE:
  - s_ready_out=0.
  - start_in=1 → FONT if FONT_EN, else LOAD.
  - On this transition clear rom_ready, overflow_err_out and rom_size_out.
- FONT:
  - Index i counts 0..79.
  - Each cycle, register mem_we_out=1, mem_addr_out=FONT_BASE+i, mem_wdata_out=font[i].
  - Font contents: standard CHIP-8 glyphs 0-F, 5 bytes each. Glyph 0 = F0 90 90 90 F0; glyph 1 = 20 60 20 20 70; ... glyph F = F0 80 F0 80 80.
  - After i=79, go to LOAD. The font phase takes exactly 80 cycles.
  - s_ready_out=0 throughout.
- LOAD:
  - s_ready_out=1, combinationally derived from state.
  - A byte is accepted when s_valid_in && s_ready_out.
  - Accepted byte with count n: on the next edge, mem_we_out=1, mem_addr_out=LOAD_BASE+n, mem_wdata_out=s_data_in, and n increments. Latency is one cycle.
  - No accept in a cycle → mem_we_out=0 next cycle.
  - An accept with s_last_in=1 writes that byte and transitions to DONE on the same edge. rom_ready=1 and rom_size_out=n+1 are registered on that edge, coincident with the last write strobe.
  - Capacity is CAP = MEM_DEPTH-LOAD_BASE. An accept when n == CAP produces no write; go to ERROR and set overflow_err_out=1. rom_size_out holds CAP.
  - A final byte exactly at n=CAP-1 with s_last_in is legal and leads to DONE.
  - start_in is ignored in FONT and LOAD.
- DONE:
  - rom_ready=1, s_ready_out=0, mem_we_out=0.
  - start_in=1 restarts the sequence as from IDLE; rom_ready drops on the next edge.
- ERROR:
  - rom_ready=0, s_ready_out=0.
  - start_in=1 restarts the sequence and clears the error.
- busy_out=1 exactly in FONT and LOAD.
- Address arithmetic is ADDR_W wide; wrap cannot occur given the capacity check.

Test Plan:
1. Default params, pulse start_in, stream 4 bytes A2 2A 60 0C with s_last on the 4th, s_valid held high → 80 font writes. mem[0]=F0, mem[5]=20, mem[79]=80. Then writes 200:A2, 201:2A, 202:60, 203:0C. rom_ready=1 and rom_size_out=4 on the edge of the 203 write. busy_out=0 afterwards.
2. FONT_EN=0, stream with s_valid toggling every other cycle → s_ready_out=1 from the cycle after start. Each write appears exactly one cycle after its accept. No writes occur in gap cycles.
3. MEM_DEPTH=4096, LOAD_BASE='h200 (CAP=3584): stream 3584 bytes with s_last on the last → final write at FFF, rom_ready=1, rom_size_out=3584, overflow_err_out=0.
4. Same as scenario 3 but s_last is never asserted and a 3585th byte is sent → no write to address 000. overflow_err_out=1, state ERROR, s_ready_out=0, rom_ready=0. Then pulse start_in → error clears and the font phase restarts.
5. Assert rst_in asynchronously mid-LOAD (after 10 bytes) → outputs go to 0 immediately, without waiting for a clock edge. No further mem_we_out. A later start performs a clean full load with rom_size_out counted from 0.
6. Pulse start_in during FONT and again during LOAD → ignored: the font index does not restart and the byte count continues. Pulse start_in in DONE → rom_ready=0 next edge and the sequence reruns.
